// File: rtl/grf_multiport.sv
// General register file: 3 combinational read ports with write bypass, 2 write
// ports (port 1 wins on collision), and a per-register pending scoreboard with
// a registered count of outstanding destinations. Register 0 is hardwired zero.
module grf_multiport #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra0_addr,
  input  logic [ADDR_W-1:0] ra1_addr,
  input  logic [ADDR_W-1:0] ra2_addr,
  output logic [DATA_W-1:0] ra0_data,
  output logic [DATA_W-1:0] ra1_data,
  output logic [DATA_W-1:0] ra2_data,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy0,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned NRD   = 3;

  // Storage and scoreboard start cleared so simulation begins in a known state.
  logic [DATA_W-1:0] regs [NREG] = '{default: '0};
  logic [NREG-1:0]   pending     = '0;

  logic [NREG-1:0]   pend_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              iss_ok;

  logic [ADDR_W-1:0] ra  [NRD];
  logic [DATA_W-1:0] rd  [NRD];
  logic              bsy [NRD];

  // Writes and issues to register 0 are discarded.
  assign wr0_ok = we0 && (wa0 != '0);
  assign wr1_ok = we1 && (wa1 != '0);
  assign iss_ok = iss_valid && (iss_addr != '0);

  assign ra[0] = ra0_addr;
  assign ra[1] = ra1_addr;
  assign ra[2] = ra2_addr;

  assign ra0_data = rd[0];
  assign ra1_data = rd[1];
  assign ra2_data = rd[2];
  assign busy0    = bsy[0];
  assign busy1    = bsy[1];
  assign busy2    = bsy[2];

  // Read ports: same-cycle write bypass (port 1 first), busy masked by a write in flight.
  always_comb begin
    for (int p = 0; p < int'(NRD); p++) begin
      rd[p]  = '0;
      bsy[p] = 1'b0;
      if (ra[p] != '0) begin
        if (wr1_ok && (wa1 == ra[p])) begin
          rd[p] = wd1;
        end else if (wr0_ok && (wa0 == ra[p])) begin
          rd[p] = wd0;
        end else begin
          rd[p] = regs[ra[p]];
        end
        bsy[p] = pending[ra[p]] &&
                 !((wr0_ok && (wa0 == ra[p])) || (wr1_ok && (wa1 == ra[p])));
      end
    end
  end

  // Next pending set: writes clear, then an issue sets so a new producer wins.
  always_comb begin
    pend_nxt = pending;
    if (wr0_ok) pend_nxt[wa0] = 1'b0;
    if (wr1_ok) pend_nxt[wa1] = 1'b0;
    if (iss_ok) pend_nxt[iss_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[i]);
    end
  end

  // Register array update; port 1 is applied last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_ok) regs[wa0] <= wd0;
      if (wr1_ok) regs[wa1] <= wd1;
    end
  end

  // Scoreboard bits and their population count move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_grf_multiport.sv
// Self-checking bench for grf_multiport: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_grf_multiport;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] ra0_addr, ra1_addr, ra2_addr;
  logic [DATA_W-1:0] ra0_data, ra1_data, ra2_data;
  logic              we0, we1;
  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              busy0, busy1, busy2;
  logic [ADDR_W:0]   pend_cnt;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [DATA_W-1:0] m_regs [NREG];
  bit                m_pend [NREG];
  int                m_cnt;

  grf_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .ra0_addr(ra0_addr), .ra1_addr(ra1_addr), .ra2_addr(ra2_addr),
    .ra0_data(ra0_data), .ra1_data(ra1_data), .ra2_data(ra2_data),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy0(busy0), .busy1(busy1), .busy2(busy2),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic bit wr_hits(input int a);
    return (we0 && wa0 != 0 && int'(wa0) == a) || (we1 && wa1 != 0 && int'(wa1) == a);
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    if (we1 && int'(wa1) == a) return wd1;
    if (we0 && int'(wa0) == a) return wd0;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    return (a != 0) && m_pend[a] && !wr_hits(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Apply what the DUT should do on the clock edge with the current inputs.
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (we0 && wa0 != 0) begin m_regs[wa0] = wd0; m_pend[wa0] = 1'b0; end
      if (we1 && wa1 != 0) begin m_regs[wa1] = wd1; m_pend[wa1] = 1'b0; end
      if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      m_cnt = 0;
      for (int i = 1; i < int'(NREG); i++) m_cnt += int'(m_pend[i]);
    end
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic step();
    #1;
    check("rd0",  64'(ra0_data), 64'(exp_rd(int'(ra0_addr))));
    check("rd1",  64'(ra1_data), 64'(exp_rd(int'(ra1_addr))));
    check("rd2",  64'(ra2_data), 64'(exp_rd(int'(ra2_addr))));
    check("busy0", 64'(busy0), 64'(exp_busy(int'(ra0_addr))));
    check("busy1", 64'(busy1), 64'(exp_busy(int'(ra1_addr))));
    check("busy2", 64'(busy2), 64'(exp_busy(int'(ra2_addr))));
    check("pend_cnt", 64'(pend_cnt), 64'(m_cnt));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    iss_valid = 1'b0; iss_addr = '0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 7));
    return ADDR_W'($urandom);
  endfunction

  initial begin
    model_reset();
    idle();
    ra0_addr = '0; ra1_addr = '0; ra2_addr = '0;
    reset = 1'b1;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    #1;
    check("reset_pend_cnt", 64'(pend_cnt), 64'd0);
    check("reset_busy0", 64'(busy0), 64'd0);
    step();

    // Write with same-cycle bypass, then stored value after the edge.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234; ra0_addr = 5'd3;
    #1;
    check("byp_w0", 64'(ra0_data), 64'h1234);
    step();
    idle();
    #1;
    check("stored_w0", 64'(ra0_data), 64'h1234);
    step();

    // Two writes to one register: port 1 wins.
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'hAAAA; wd1 = 32'h5555;
    ra1_addr = 5'd7;
    #1;
    check("byp_collide", 64'(ra1_data), 64'h5555);
    step();
    idle();
    #1;
    check("stored_collide", 64'(ra1_data), 64'h5555);
    step();

    // Register 0 ignores writes and issues.
    we1 = 1'b1; wa1 = '0; wd1 = 32'hFFFF_FFFF; iss_valid = 1'b1; iss_addr = '0; ra2_addr = '0;
    #1;
    check("r0_byp", 64'(ra2_data), 64'd0);
    step();
    idle();
    #1;
    check("r0_rd", 64'(ra2_data), 64'd0);
    check("r0_busy", 64'(busy2), 64'd0);
    check("r0_cnt", 64'(pend_cnt), 64'd0);
    step();

    // Issue 5 and 9, then retire 5.
    iss_valid = 1'b1; iss_addr = 5'd5; step();
    iss_addr = 5'd9; step();
    idle(); ra0_addr = 5'd5;
    #1;
    check("iss_cnt2", 64'(pend_cnt), 64'd2);
    check("iss_busy5", 64'(busy0), 64'd1);
    step();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h55;
    #1;
    check("wr_busy_mask", 64'(busy0), 64'd0);
    step();
    idle();
    #1;
    check("retire_cnt1", 64'(pend_cnt), 64'd1);
    step();

    // Issue and write of the same pending register: stays pending.
    iss_valid = 1'b1; iss_addr = 5'd4; step();
    idle(); #1;
    check("pre_cnt", 64'(pend_cnt), 64'd2);
    iss_valid = 1'b1; iss_addr = 5'd4; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44;
    step();
    idle(); ra1_addr = 5'd4;
    #1;
    check("set_wins_cnt", 64'(pend_cnt), 64'd2);
    check("set_wins_busy", 64'(busy1), 64'd1);
    step();

    // Reset mid-operation with 3 pending and register 2 holding data.
    iss_valid = 1'b1; iss_addr = 5'd2; we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hBEEF; step();
    idle(); ra2_addr = 5'd2;
    #1;
    check("pre_rst_cnt", 64'(pend_cnt), 64'd3);
    check("pre_rst_r2", 64'(ra2_data), 64'hBEEF);
    step();
    reset = 1'b1; iss_valid = 1'b1; iss_addr = 5'd11; we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h77;
    step();
    idle(); ra0_addr = 5'd9; ra1_addr = 5'd4;
    #1;
    check("post_rst_cnt", 64'(pend_cnt), 64'd0);
    check("post_rst_r2", 64'(ra2_data), 64'd0);
    check("post_rst_busy0", 64'(busy0), 64'd0);
    check("post_rst_busy1", 64'(busy1), 64'd0);
    check("post_rst_busy2", 64'(busy2), 64'd0);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      we0       = 1'($urandom);
      we1       = 1'($urandom);
      wa0       = rand_addr();
      wa1       = rand_addr();
      wd0       = $urandom;
      wd1       = $urandom;
      iss_valid = ($urandom_range(0, 2) != 0);
      iss_addr  = rand_addr();
      ra0_addr  = rand_addr();
      ra1_addr  = rand_addr();
      ra2_addr  = rand_addr();
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/grf_multiport.md
GRF_MULTIPORT -- requirements
Module: grf_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; register count NREG = 2**ADDR_W.
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-004 SHALL have ports: ra0_addr, ra1_addr, ra2_addr  in  ADDR_W  read addresses.
REQ-005 SHALL have ports: ra0_data, ra1_data, ra2_data  out  DATA_W  read data.
REQ-006 SHALL have ports: we0, we1  in  1  write enables; wa0, wa1  in  ADDR_W  write addresses; wd0, wd1  in  DATA_W  write data.
REQ-007 SHALL have ports: iss_valid  in  1  mark destination pending; iss_addr  in  ADDR_W  destination register.
REQ-008 SHALL have ports: busy0, busy1, busy2  out  1  pending status of the register on the matching read port.
REQ-009 SHALL have port: pend_cnt  out  ADDR_W+1  number of pending registers.

Function
REQ-010 SHALL hold NREG registers of DATA_W bits; register 0 SHALL always read 0 and SHALL ignore writes, issues and bypass.
REQ-011 SHALL write wdN to register waN at the rising clk edge when weN=1 and waN!=0.
REQ-012 SHALL, when we0=we1=1 and wa0=wa1!=0, store wd1 (port 1 priority); wd0 is dropped.
REQ-013 SHALL drive read data combinationally (zero latency); addr 0 -> 0; else wd1 if we1 and wa1 matches; else wd0 if we0 and wa0 matches; else stored value.
REQ-014 SHALL keep one pending bit per register; registers 1..NREG-1 only.
REQ-015 SHALL set pending[iss_addr] at clk edge when iss_valid=1 and iss_addr!=0.
REQ-016 SHALL clear pending[waN] at clk edge for each accepted write (weN=1, waN!=0).
REQ-017 SHALL, when a set and a clear target the same register in one cycle, leave the bit set (new producer wins).
REQ-018 SHALL drive busyN = pending[raN_addr] AND NOT (a write to raN_addr this cycle); busyN=0 for addr 0.
REQ-019 SHALL drive pend_cnt as a registered popcount of the pending bits, updated in the same edge as the bits; range 0..NREG-1, no wrap.
REQ-020 SHALL treat iss_valid to an already-pending register as a no-op on pend_cnt; a clear of a non-pending register SHALL likewise not change pend_cnt.

Reset
REQ-021 SHALL, on a clk edge with reset=1, clear all registers to 0, all pending bits to 0, pend_cnt to 0; writes and issues in that cycle are ignored.
REQ-022 SHALL, while reset=1, still apply REQ-013 bypass combinationally; stored state after release SHALL be all zero.
REQ-023 SHALL come out of reset-mid-operation with no residual pending bits or stored data.
REQ-024 SHALL, in simulation, initialise all registers and pending bits to 0 at time 0.

Verification
REQ-025 SHALL cover: we0=1 wa0=3 wd0=0x1234 with ra0_addr=3 -> ra0_data=0x1234 same cycle; next cycle we0=0 -> still 0x1234.
REQ-026 SHALL cover: we0=we1=1 wa0=wa1=7 wd0=0xAAAA wd1=0x5555 -> ra1_data=0x5555 same cycle and stored 0x5555 after edge.
REQ-027 SHALL cover: we1=1 wa1=0 wd1=0xFFFFFFFF, iss_valid=1 iss_addr=0 -> ra2_addr=0 reads 0, busy2=0, pend_cnt=0.
REQ-028 SHALL cover: issue 5, then issue 9 -> pend_cnt=2, busy0=1 for addr 5; write 5 -> busy0=0 in write cycle, pend_cnt=1 after edge.
REQ-029 SHALL cover: iss_valid=1 iss_addr=4 with we0=1 wa0=4 same cycle (4 pending) -> pending[4] stays 1, pend_cnt unchanged.
REQ-030 SHALL cover: 3 pending + register 2=0xBEEF, assert reset one cycle -> pend_cnt=0, all busyN=0, register 2 reads 0.
